// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
//   SPI-mode SD command engine. Frames {cmd_number, cmd_args, cmd_crc} and
//   shifts it out MSB first on D1, then collects the R1 byte from D0. It can
//   also collect a 32-bit R7 trailer, or the first 32 bits of a data block
//   and its 16 CRC bits. It owns CS and all per-bit timing.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               level request, held by the sequencer until done
//   cmd_number/args/crc command frame fields
//   rsp_type            0=R1, 1=R1+R7 trailer, 2=R1+data block, 3=as 0
//   D0 / D1             MISO in / MOSI out
//   CS                  chip select, active-low
//   response_flags      R1 byte (0xFF on R1 timeout)
//   response_data       R7 trailer or first 32 data bits
//   timeout, busy, done status
//
// state      | meaning
// IDLE       | CS high, waiting for start
// PRE        | PRE_BITS dummy ones with CS low
// SEND       | 48 command bits on D1
// WAIT_R1    | waiting for the R1 start bit (0)
// R1         | remaining 7 R1 bits
// TRAIL      | 32-bit R7 trailer
// WAIT_TOKEN | waiting for the data token's final 0 bit
// DATA       | 32 data bits
// CRC        | 16 data CRC bits, discarded
// POST       | POST_BITS dummy ones with CS low
// DONE       | done high until start drops
module sd_cmd_engine #(
    parameter int NCR_MAX   = 64,
    parameter int TOKEN_MAX = 2048,
    parameter int PRE_BITS  = 8,
    parameter int POST_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd_number,
    input  logic [31:0] cmd_args,
    input  logic [7:0]  cmd_crc,
    input  logic [1:0]  rsp_type,
    input  logic        D0,
    output logic        D1,
    output logic        CS,
    output logic [7:0]  response_flags,
    output logic [31:0] response_data,
    output logic        timeout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SEND, S_WAIT_R1, S_R1, S_TRAIL,
        S_WAIT_TOKEN, S_DATA, S_CRC, S_POST, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] frame_q, frame_d;
    logic [1:0]  rsp_type_q, rsp_type_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] wait_cnt_q, wait_cnt_d;
    logic [5:0]  r1_sr_q, r1_sr_d;
    logic [7:0]  flags_q, flags_d;
    logic [31:0] data_q, data_d;
    logic        timeout_q, timeout_d;
    logic        cs_q, cs_d;
    logic        d1_q, d1_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  send_idx;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        rsp_type_d = rsp_type_q;
        bit_cnt_d  = bit_cnt_q + 6'd1;
        wait_cnt_d = wait_cnt_q + 12'd1;
        r1_sr_d    = r1_sr_q;
        flags_d    = flags_q;
        data_d     = data_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d    = {cmd_number, cmd_args, cmd_crc};
                    rsp_type_d = (rsp_type == 2'd3) ? 2'd0 : rsp_type;
                    timeout_d  = 1'b0;
                    state_d    = S_PRE;
                end
            end
            S_PRE: begin
                if (bit_cnt_q == 6'(PRE_BITS - 1)) state_d = S_SEND;
            end
            S_SEND: begin
                if (bit_cnt_q == 6'd47) state_d = S_WAIT_R1;
            end
            S_WAIT_R1: begin
                // A start bit on the last allowed sample still counts.
                if (!D0) begin
                    state_d = S_R1;
                end else if (wait_cnt_q == 12'(NCR_MAX - 1)) begin
                    flags_d   = 8'hFF;
                    timeout_d = 1'b1;
                    state_d   = S_POST;
                end
            end
            S_R1: begin
                r1_sr_d = {r1_sr_q[4:0], D0};
                if (bit_cnt_q == 6'd6) begin
                    // Bit 7 was the 0 start bit seen in WAIT_R1.
                    flags_d = {1'b0, r1_sr_q, D0};
                    if (flags_d[7:1] != 7'd0)    state_d = S_POST;
                    else if (rsp_type_q == 2'd1) state_d = S_TRAIL;
                    else if (rsp_type_q == 2'd2) state_d = S_WAIT_TOKEN;
                    else                         state_d = S_POST;
                end
            end
            S_TRAIL: begin
                data_d = {data_q[30:0], D0};
                if (bit_cnt_q == 6'd31) state_d = S_POST;
            end
            S_WAIT_TOKEN: begin
                // Token 0xFE: its only 0 is the last bit, so any 0 ends it.
                if (!D0) begin
                    state_d = S_DATA;
                end else if (wait_cnt_q == 12'(TOKEN_MAX - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_POST;
                end
            end
            S_DATA: begin
                data_d = {data_q[30:0], D0};
                if (bit_cnt_q == 6'd31) state_d = S_CRC;
            end
            S_CRC: begin
                if (bit_cnt_q == 6'd15) state_d = S_POST;
            end
            S_POST: begin
                if (bit_cnt_q == 6'(POST_BITS - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            bit_cnt_d  = 6'd0;
            wait_cnt_d = 12'd0;
        end

        // Pin outputs follow the state being entered so they are registered
        // in step with it.
        send_idx = 6'd47 - bit_cnt_d;
        cs_d     = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d   = !cs_d;
        done_d   = (state_d == S_DONE);
        d1_d     = (state_d == S_SEND) ? frame_q[send_idx] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            rsp_type_q <= 2'd0;
            bit_cnt_q  <= 6'd0;
            wait_cnt_q <= 12'd0;
            r1_sr_q    <= 6'd0;
            flags_q    <= 8'hFF;
            data_q     <= 32'd0;
            timeout_q  <= 1'b0;
            cs_q       <= 1'b1;
            d1_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            rsp_type_q <= rsp_type_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            r1_sr_q    <= r1_sr_d;
            flags_q    <= flags_d;
            data_q     <= data_d;
            timeout_q  <= timeout_d;
            cs_q       <= cs_d;
            d1_q       <= d1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign D1             = d1_q;
    assign CS             = cs_q;
    assign response_flags = flags_q;
    assign response_data  = data_q;
    assign timeout        = timeout_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cmd_number;
    logic [31:0] cmd_args;
    logic [7:0]  cmd_crc;
    logic [1:0]  rsp_type;
    logic        D0;
    logic        D1;
    logic        CS;
    logic [7:0]  response_flags;
    logic [31:0] response_data;
    logic        timeout;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] fr;
    int          dk;
    int          pb;

    always #5 clk = ~clk;

    sd_cmd_engine dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cmd_number     (cmd_number),
        .cmd_args       (cmd_args),
        .cmd_crc        (cmd_crc),
        .rsp_type       (rsp_type),
        .D0             (D0),
        .D1             (D1),
        .CS             (CS),
        .response_flags (response_flags),
        .response_data  (response_data),
        .timeout        (timeout),
        .busy           (busy),
        .done           (done)
    );

    // Drives one command from a negedge. Edge k=0 is the first posedge that
    // sees start. The card stream begins on the first WAIT_R1 sample (k=57):
    // 8 PRE edges, 48 SEND edges. Outputs are observed at the negedge after
    // each edge; D1 after edges 8..55 carries the frame MSB first.
    task automatic run_cmd(input logic [7:0] c, input logic [31:0] a,
                           input logic [7:0] cr, input logic [1:0] rt,
                           input logic [127:0] st, input int nb,
                           input int drop_at, input int rst_at,
                           output logic [47:0] frame, output int done_k,
                           output int pre_bad);
        int k;
        int j;
        cmd_number = c;
        cmd_args   = a;
        cmd_crc    = cr;
        rsp_type   = rt;
        start      = 1'b1;
        frame      = '0;
        done_k     = -1;
        pre_bad    = 0;
        k          = 0;
        while (k < 3000) begin
            j  = k - 57;
            D0 = (j >= 0 && j < nb) ? st[nb - 1 - j] : 1'b1;
            if (k == drop_at) start = 1'b0;
            if (k == rst_at)  reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (k == rst_at) break;
            if (k < 8 && (CS !== 1'b0 || D1 !== 1'b1)) pre_bad++;
            if (k >= 8 && k < 56) frame[55 - k] = D1;
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            k++;
        end
        D0 = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; D0 = 1'b1;
        cmd_number = 8'h00; cmd_args = 32'h0; cmd_crc = 8'h00; rsp_type = 2'd0;
        repeat (3) @(negedge clk);
        n_vec++; if (CS !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b want 1", CS); end
        n_vec++; if (D1 !== 1'b1) begin n_err++; $display("FAIL reset_d1: got %b want 1", D1); end
        n_vec++; if (done !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_err++; $display("FAIL reset_status: got done=%b busy=%b timeout=%b want 0 0 0", done, busy, timeout); end
        n_vec++; if (response_flags !== 8'hFF) begin n_err++; $display("FAIL reset_flags: got %h want ff", response_flags); end
        n_vec++; if (response_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", response_data); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (CS !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_hold: got cs=%b busy=%b want 1 0", CS, busy); end
    endtask

    task automatic test_cmd0();
        run_cmd(8'h40, 32'h0, 8'h95, 2'd0, 128'({3'b111, 8'h01}), 11, -1, -1, fr, dk, pb);
        n_vec++; if (pb !== 0) begin n_err++; $display("FAIL cmd0_pre: got %0d bad PRE cycles want 0", pb); end
        n_vec++; if (fr !== 48'h400000000095) begin n_err++; $display("FAIL cmd0_frame: got %h want 400000000095", fr); end
        n_vec++; if (dk !== 75) begin n_err++; $display("FAIL cmd0_done_edge: got %0d want 75", dk); end
        n_vec++; if (response_flags !== 8'h01) begin n_err++; $display("FAIL cmd0_flags: got %h want 01", response_flags); end
        n_vec++; if (timeout !== 1'b0 || CS !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL cmd0_done_state: got timeout=%b cs=%b busy=%b want 0 1 0", timeout, CS, busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL cmd0_done_hold: got %b want 1", done); end
        start = 1'b0;
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || CS !== 1'b1) begin
            n_err++; $display("FAIL cmd0_release: got done=%b cs=%b want 0 1", done, CS); end
    endtask

    task automatic test_cmd8();
        // start drops mid-frame; done must still pulse for one cycle.
        run_cmd(8'h48, 32'h000001AA, 8'h87, 2'd1, 128'({8'h01, 32'h000001AA}), 40, 30, -1, fr, dk, pb);
        n_vec++; if (fr !== 48'h48000001AA87) begin n_err++; $display("FAIL cmd8_frame: got %h want 48000001aa87", fr); end
        n_vec++; if (dk !== 104) begin n_err++; $display("FAIL cmd8_done_edge: got %0d want 104", dk); end
        n_vec++; if (response_data !== 32'h000001AA) begin n_err++; $display("FAIL cmd8_data: got %h want 000001aa", response_data); end
        n_vec++; if (response_flags !== 8'h01) begin n_err++; $display("FAIL cmd8_flags: got %h want 01", response_flags); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL cmd8_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_cmd17();
        run_cmd(8'h51, 32'h00000200, 8'h55, 2'd2,
                128'({8'h00, 20'hFFFFF, 8'hFE, 32'hDEADBEEF, 16'h1234}), 84, -1, -1, fr, dk, pb);
        n_vec++; if (fr !== 48'h510000020055) begin n_err++; $display("FAIL cmd17_frame: got %h want 510000020055", fr); end
        n_vec++; if (dk !== 148) begin n_err++; $display("FAIL cmd17_done_edge: got %0d want 148", dk); end
        n_vec++; if (response_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL cmd17_data: got %h want deadbeef", response_data); end
        n_vec++; if (response_flags !== 8'h00 || timeout !== 1'b0) begin
            n_err++; $display("FAIL cmd17_status: got flags=%h timeout=%b want 00 0", response_flags, timeout); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        run_cmd(8'h51, 32'h00000400, 8'h00, 2'd2, 128'(8'h05), 8, -1, -1, fr, dk, pb);
        n_vec++; if (dk !== 72) begin n_err++; $display("FAIL illegal_done_edge: got %0d want 72", dk); end
        n_vec++; if (response_flags !== 8'h05) begin n_err++; $display("FAIL illegal_flags: got %h want 05", response_flags); end
        n_vec++; if (response_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL illegal_data_held: got %h want deadbeef", response_data); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_token_timeout();
        run_cmd(8'h51, 32'h0, 8'h00, 2'd2, 128'(8'h00), 8, -1, -1, fr, dk, pb);
        n_vec++; if (dk !== 2120) begin n_err++; $display("FAIL token_to_done_edge: got %0d want 2120", dk); end
        n_vec++; if (timeout !== 1'b1 || response_flags !== 8'h00) begin
            n_err++; $display("FAIL token_to_status: got timeout=%b flags=%h want 1 00", timeout, response_flags); end
        n_vec++; if (response_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL token_to_data: got %h want deadbeef", response_data); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_response();
        run_cmd(8'h40, 32'h0, 8'h95, 2'd3, 128'(0), 0, -1, -1, fr, dk, pb);
        n_vec++; if (dk !== 128) begin n_err++; $display("FAIL noresp_done_edge: got %0d want 128", dk); end
        n_vec++; if (response_flags !== 8'hFF || timeout !== 1'b1) begin
            n_err++; $display("FAIL noresp_status: got flags=%h timeout=%b want ff 1", response_flags, timeout); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_late_r1();
        // Start bit on the 64th sample is still accepted; timeout clears.
        run_cmd(8'h40, 32'h0, 8'h95, 2'd0, 128'({63'h7FFF_FFFF_FFFF_FFFF, 8'h00}), 71, -1, -1, fr, dk, pb);
        n_vec++; if (dk !== 135) begin n_err++; $display("FAIL late_r1_done_edge: got %0d want 135", dk); end
        n_vec++; if (response_flags !== 8'h00 || timeout !== 1'b0) begin
            n_err++; $display("FAIL late_r1_status: got flags=%h timeout=%b want 00 0", response_flags, timeout); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        run_cmd(8'h40, 32'h0, 8'h95, 2'd0, 128'({3'b111, 8'h01}), 11, -1, 29, fr, dk, pb);
        n_vec++; if (CS !== 1'b1 || D1 !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pins: got cs=%b d1=%b want 1 1", CS, D1); end
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_status: got done=%b busy=%b want 0 0", done, busy); end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || CS !== 1'b1) begin
            n_err++; $display("FAIL rstmid_no_done: got done=%b cs=%b want 0 1", done, CS); end
        run_cmd(8'h40, 32'h0, 8'h95, 2'd0, 128'({3'b111, 8'h01}), 11, -1, -1, fr, dk, pb);
        n_vec++; if (fr !== 48'h400000000095 || pb !== 0) begin
            n_err++; $display("FAIL rstmid_refresh_frame: got %h pre_bad=%0d want 400000000095 0", fr, pb); end
        n_vec++; if (dk !== 75 || response_flags !== 8'h01) begin
            n_err++; $display("FAIL rstmid_refresh_done: got edge=%0d flags=%h want 75 01", dk, response_flags); end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        D0    = 1'b1;
        @(negedge clk);
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd17();
        test_illegal();
        test_token_timeout();
        test_no_response();
        test_late_r1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
